// File: rtl/ex_pkg.sv
// ex_pkg: shared types and defaults for the EX/MEM stage.
//   ExW / ExRa  : default datapath and register-address widths
//   ex_state_e  : stage state (StRun, StTrap)
//   ex_ctrl_t   : control bundle carried with each instruction
//   sat_inc16   : saturating 16-bit increment for event counters
package ex_pkg;

  localparam int unsigned ExW  = 16;
  localparam int unsigned ExRa = 3;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StTrap = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t CtrlNone = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ex_flag_gen.sv
// ex_flag_gen: combinational zero/negative flags of a W-bit two's-complement value.
// Ports:
//   i_value : value to inspect
//   o_zero  : i_value == 0
//   o_neg   : sign bit of i_value
module ex_flag_gen
  import ex_pkg::*;
#(
  parameter int unsigned W = ExW
) (
  input  logic [W-1:0] i_value,
  output logic         o_zero,
  output logic         o_neg
);

  assign o_zero = (i_value == '0);
  assign o_neg  = i_value[W-1];

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register behind the 16-bit adder/ALU.
// Registers the ALU result, carry, destination and control bits; derives zero/neg;
// traps on signed overflow (squashing side effects) and holds StTrap until i_exc_ack.
// Valid/ready handshake on both sides; synchronous active-high reset.
// Optional feature (macro EX_OVF_COUNT_EN): o_ovf_count / o_wrap_count saturating
// 16-bit counters of signed-overflow traps and unsigned wraps.
// Ports:
//   i_clk, i_rst                 : clock, synchronous reset
//   i_flush                      : drop held and incoming entries
//   i_in_valid / o_in_ready      : EX-side handshake
//   i_alu_s, i_alu_v, i_alu_cout : adder result and status
//   i_ovf_trap                   : signed op, overflow must trap
//   i_pc_in, i_rd_in, i_reg_write_in, i_mem_read_in, i_mem_write_in, i_store_data_in
//   o_out_valid / i_out_ready    : MEM-side handshake
//   o_alu_res, o_zero, o_neg, o_carry, o_rd_out, o_reg_write_out, o_mem_read_out,
//   o_mem_write_out, o_store_data_out : registered entry
//   o_exc, o_epc                 : one-cycle exception pulse and faulting PC
//   i_exc_ack                    : leave StTrap
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned W  = ExW,
  parameter int unsigned RA = ExRa
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [W-1:0]  i_alu_s,
  input  logic          i_alu_v,
  input  logic          i_alu_cout,
  input  logic          i_ovf_trap,
  input  logic [W-1:0]  i_pc_in,
  input  logic [RA-1:0] i_rd_in,
  input  logic          i_reg_write_in,
  input  logic          i_mem_read_in,
  input  logic          i_mem_write_in,
  input  logic [W-1:0]  i_store_data_in,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [W-1:0]  o_alu_res,
  output logic          o_zero,
  output logic          o_neg,
  output logic          o_carry,
  output logic [RA-1:0] o_rd_out,
  output logic          o_reg_write_out,
  output logic          o_mem_read_out,
  output logic          o_mem_write_out,
  output logic [W-1:0]  o_store_data_out,
  output logic          o_exc,
  output logic [W-1:0]  o_epc,
  input  logic          i_exc_ack
`ifdef EX_OVF_COUNT_EN
  ,
  output logic [15:0]   o_ovf_count,
  output logic [15:0]   o_wrap_count
`endif
);

  ex_state_e     r_state;
  logic          r_out_valid;
  logic [W-1:0]  r_alu_res;
  logic          r_zero;
  logic          r_neg;
  logic          r_carry;
  logic [RA-1:0] r_rd;
  ex_ctrl_t      r_ctrl;
  logic [W-1:0]  r_store_data;
  logic          r_exc;
  logic [W-1:0]  r_epc;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_take;
  logic          w_trap;
  logic          w_zero;
  logic          w_neg;
  ex_ctrl_t      w_ctrl_in;

  ex_flag_gen #(
    .W (W)
  ) u_flag_gen (
    .i_value (i_alu_s),
    .o_zero  (w_zero),
    .o_neg   (w_neg)
  );

  assign w_in_ready = (r_state == StRun) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;
  // Flush discards the incoming entry, so it can neither register nor trap.
  assign w_take     = w_accept && !i_flush;
  assign w_trap     = w_take && i_ovf_trap && i_alu_v;

  assign w_ctrl_in = '{
    reg_write: i_reg_write_in,
    mem_read:  i_mem_read_in,
    mem_write: i_mem_write_in
  };

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StRun;
      r_out_valid  <= 1'b0;
      r_alu_res    <= '0;
      r_zero       <= 1'b1;
      r_neg        <= 1'b0;
      r_carry      <= 1'b0;
      r_rd         <= '0;
      r_ctrl       <= CtrlNone;
      r_store_data <= '0;
      r_exc        <= 1'b0;
      r_epc        <= '0;
    end else begin
      r_exc <= w_trap;
      if (w_trap) begin
        r_epc <= i_pc_in;
      end

      if (i_flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_alu_res    <= i_alu_s;
        r_zero       <= w_zero;
        r_neg        <= w_neg;
        r_carry      <= i_alu_cout;
        r_rd         <= i_rd_in;
        // Faulting instruction still flows to MEM but with no side effects.
        r_ctrl       <= w_trap ? CtrlNone : w_ctrl_in;
        r_store_data <= i_store_data_in;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        StRun:   if (w_trap) r_state <= StTrap;
        StTrap:  if (i_exc_ack) r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

`ifdef EX_OVF_COUNT_EN
  logic [15:0] r_ovf_count;
  logic [15:0] r_wrap_count;
  logic        w_wrap;

  assign w_wrap = w_take && !i_ovf_trap && i_alu_cout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      if (w_trap) r_ovf_count <= sat_inc16(r_ovf_count);
      if (w_wrap) r_wrap_count <= sat_inc16(r_wrap_count);
    end
  end

  assign o_ovf_count  = r_ovf_count;
  assign o_wrap_count = r_wrap_count;
`endif

  assign o_in_ready       = w_in_ready;
  assign o_out_valid      = r_out_valid;
  assign o_alu_res        = r_alu_res;
  assign o_zero           = r_zero;
  assign o_neg            = r_neg;
  assign o_carry          = r_carry;
  assign o_rd_out         = r_rd;
  assign o_reg_write_out  = r_ctrl.reg_write;
  assign o_mem_read_out   = r_ctrl.mem_read;
  assign o_mem_write_out  = r_ctrl.mem_write;
  assign o_store_data_out = r_store_data;
  assign o_exc            = r_exc;
  assign o_epc            = r_epc;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the 16-bit two's-complement adder/ALU.
- Registers the adder result, its V/cout status and the control bits carried alongside the operation.
- Derives zero/negative flags and detects signed-overflow exceptions, squashing the faulting instruction's side effects.
- Uses a valid/ready handshake so the MEM stage can stall; holds a trap state until the exception is acknowledged.

Parameters:
- W, 16, datapath width (result, store data, PC)
- RA, 3, register-file address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash the held entry and the incoming entry (branch or exception redirect)
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage accepts this cycle
- alu_s  in  W  adder sum/difference
- alu_v  in  1  adder overflow status
- alu_cout  in  1  adder carry out
- ovf_trap  in  1  op is signed add/sub (overflow must trap); 0 for unsigned ops
- pc_in  in  W  PC of the EX instruction
- rd_in  in  RA  destination register
- reg_write_in  in  1  writeback enable
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- store_data_in  in  W  store data
- out_valid  out  1  entry valid to MEM
- out_ready  in  1  MEM accepts this cycle
- alu_res  out  W  registered result
- zero  out  1  alu_res == 0
- neg  out  1  alu_res[W-1]
- carry  out  1  registered alu_cout
- rd_out  out  RA  registered destination register
- reg_write_out  out  1  registered writeback enable (squashed on trap)
- mem_read_out  out  1  registered load (squashed on trap)
- mem_write_out  out  1  registered store (squashed on trap)
- store_data_out  out  W  registered store data
- exc  out  1  one-cycle overflow-exception pulse
- epc  out  W  PC of the faulting instruction
- exc_ack  in  1  controller has redirected; leave TRAP

Behaviour:
- Reset: all outputs 0; state RUN.
  - Covers out_valid, alu_res, carry, rd_out, all control outputs, store_data_out, exc and epc.
  - zero=1, because it is derived from alu_res = 0.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept: in_valid && in_ready.
  - Latency 1 cycle: all in_* fields are registered and out_valid=1 next cycle.
- Hold: out_valid && !out_ready means every registered output is held stable.
- Drain: out_ready && !accept means out_valid goes to 0 next cycle. Data fields may keep stale values.
- Trap condition: accept && ovf_trap && alu_v.
  - Entry is still registered, with out_valid=1 and reg_write_out=mem_read_out=mem_write_out=0.
  - exc=1 for exactly the next cycle.
  - epc <= pc_in.
  - state -> TRAP.
- No trap when ovf_trap=0, even if alu_v=1. The unsigned wrap result passes through normally.
- TRAP: in_ready=0. The held entry still drains normally.
  - exc_ack -> RUN the next cycle.
  - exc_ack while in RUN is ignored.
- epc holds its value until the next trap.
- flush (priority over accept): out_valid <= 0 next cycle. The incoming entry is discarded, so no trap or exc fires from it.
  - flush does not leave TRAP; only exc_ack or rst does.
- Flush while out_valid && !out_ready: the entry is dropped anyway.
- Reset mid-trap or mid-stall returns to the reset state in 1 cycle; nothing pending survives.
- zero and neg are registered and derived from alu_res; they are not recomputed combinationally downstream.

Optional Feature:
- Macro: EX_OVF_COUNT_EN.
- Defined:
  - Extra output ovf_count[15:0], reset 0.
  - Increments on each trap condition; saturates at 16'hFFFF.
  - Also counts unsigned wraps (accept && !ovf_trap && alu_cout) on a separate output wrap_count[15:0], same rules.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package ex_pkg: W and RA defaults, the state enum (RUN, TRAP), and the ctrl bundle struct {reg_write, mem_read, mem_write}.
- One natural sub-module: ex_flag_gen (combinational zero/neg from a W-bit value), reusable by the branch compare.
- Everything else stays in ex_mem_stage.

Test Plan:
- Reset, then unsigned add: alu_s=16'h0005, cout=0, out_ready=1 -> next cycle out_valid=1, alu_res=5, zero=0, neg=0, reg_write_out follows input.
- Stall: accept alu_s=16'h1234, hold out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs held at 16'h1234; release -> 1234 drains, next entry accepted.
- Signed overflow: X=16'h7FFF+1 gives alu_s=16'h8000, alu_v=1, ovf_trap=1, pc_in=16'h0040 -> exc one cycle, epc=16'h0040, reg_write_out=0, in_ready=0 until exc_ack, RUN the cycle after exc_ack.
- Unsigned wrap: 16'hFFFF+1 gives alu_s=0, alu_v=0, cout=1, ovf_trap=0 -> no exc, zero=1, carry=1, reg_write_out=1.
- Flush with simultaneous accept of an overflowing op -> out_valid=0 next cycle, exc never asserts, epc unchanged.
- rst asserted while in TRAP with out_ready=0 -> next cycle state RUN, out_valid=0, exc=0, in_ready=1.
